// File: rtl/tpu_ctrl.sv
// Purpose : sequencer between ID/EX and the systolic-array TPU. It forwards A/B/C operand
//           loads and runs a fixed CYC-cycle compute phase on each start command.
// Latency : an accepted write reaches tpu_* one cycle later. A start gives CYC cycles of
//           tpu_en_o, then a one-cycle DONE, so start-to-start is CYC+2 cycles.
// Backpr. : stall_o (combinational) is high while busy and a TPU command is presented. The
//           stalled command is not consumed, and ID/EX re-presents it until IDLE.
// Ports   : clk_i, rst_n_i (async, active low); start_i, wren_{A,B,C}_i, row_i, col_i,
//           data_i from ID/EX; tpu_{A,B,C}_we_o, tpu_row_o, tpu_col_o, tpu_data_o,
//           tpu_en_o, tpu_cycle_o to the array; busy_o, done_o, stall_o, err_o status;
//           perf_busy_o, perf_stall_o counters.
// Config  : define TPU_CTRL_PERF_EN to build the saturating perf counters. Without it the
//           counter ports read 0.
module tpu_ctrl #(
  parameter int DIM    = 8,
  parameter int DATA_W = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            start_i,
  input  logic                            wren_A_i,
  input  logic                            wren_B_i,
  input  logic                            wren_C_i,
  input  logic [4:0]                      row_i,
  input  logic [4:0]                      col_i,
  input  logic [DATA_W-1:0]               data_i,
  output logic                            tpu_A_we_o,
  output logic                            tpu_B_we_o,
  output logic                            tpu_C_we_o,
  output logic [4:0]                      tpu_row_o,
  output logic [4:0]                      tpu_col_o,
  output logic [DATA_W-1:0]               tpu_data_o,
  output logic                            tpu_en_o,
  output logic [$clog2(3*DIM-2+1)-1:0]    tpu_cycle_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            stall_o,
  output logic                            err_o,
  output logic [31:0]                     perf_busy_o,
  output logic [31:0]                     perf_stall_o
);

  localparam int CYC = 3*DIM - 2;
  localparam int CW  = $clog2(CYC+1);

  typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, DONE = 2'd2} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          any_wr;
  logic          in_range;
  logic          idle;
  logic          wr_ok;

  // Compare in 6 bits so that DIM = 32 does not wrap the constant.
  assign in_range = ({1'b0, row_i} < 6'(DIM)) && ({1'b0, col_i} < 6'(DIM));
  assign any_wr   = wren_A_i | wren_B_i | wren_C_i;
  assign idle     = (state == IDLE);
  assign wr_ok    = idle && in_range;

  // Combinational so the stall reaches the pipeline in the same cycle as the command.
  assign stall_o     = busy_o & (start_i | any_wr);
  assign tpu_cycle_o = cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      cnt      <= '0;
      tpu_en_o <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state    <= COMPUTE;
            cnt      <= '0;
            tpu_en_o <= 1'b1;
            busy_o   <= 1'b1;
          end
        end
        COMPUTE: begin
          if (cnt == CW'(CYC-1)) begin
            state    <= DONE;
            cnt      <= '0;
            tpu_en_o <= 1'b0;
            done_o   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          tpu_en_o <= 1'b0;
          busy_o   <= 1'b0;
          done_o   <= 1'b0;
        end
      endcase
    end
  end

  // Write path: every legal accepted write is forwarded for one cycle. Index and data
  // return to 0 when no write is being forwarded.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tpu_A_we_o <= 1'b0;
      tpu_B_we_o <= 1'b0;
      tpu_C_we_o <= 1'b0;
      tpu_row_o  <= '0;
      tpu_col_o  <= '0;
      tpu_data_o <= '0;
      err_o      <= 1'b0;
    end else begin
      tpu_A_we_o <= wr_ok & wren_A_i;
      tpu_B_we_o <= wr_ok & wren_B_i;
      tpu_C_we_o <= wr_ok & wren_C_i;
      tpu_row_o  <= (wr_ok & any_wr) ? row_i  : '0;
      tpu_col_o  <= (wr_ok & any_wr) ? col_i  : '0;
      tpu_data_o <= (wr_ok & any_wr) ? data_i : '0;
      if (idle && any_wr && !in_range)
        err_o <= 1'b1;
    end
  end

`ifdef TPU_CTRL_PERF_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy_o && (perf_busy_q != 32'hFFFF_FFFF))
        perf_busy_q <= perf_busy_q + 32'd1;
      if (stall_o && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_busy_o  = perf_busy_q;
  assign perf_stall_o = perf_stall_q;
`else
  assign perf_busy_o  = 32'd0;
  assign perf_stall_o = 32'd0;
`endif

endmodule

// File: tb/tb_tpu_ctrl.sv
// Purpose : directed self-checking bench for tpu_ctrl with DIM=8, so CYC=22.
// Latency : outputs are sampled on the falling edge. Inputs change on the falling edge too,
//           and take effect at the next rising edge.
// Backpr. : the stall scenario holds a write across the busy window, as ID/EX would.
module tb_tpu_ctrl;

  localparam int DIM = 8;
  localparam int DW  = 32;
  localparam int CYC = 3*DIM - 2;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic          wren_A_i = 1'b0, wren_B_i = 1'b0, wren_C_i = 1'b0;
  logic [4:0]    row_i = '0, col_i = '0;
  logic [DW-1:0] data_i = '0;
  logic          tpu_A_we_o, tpu_B_we_o, tpu_C_we_o;
  logic [4:0]    tpu_row_o, tpu_col_o;
  logic [DW-1:0] tpu_data_o;
  logic          tpu_en_o;
  logic [4:0]    tpu_cycle_o;
  logic          busy_o, done_o, stall_o, err_o;
  logic [31:0]   perf_busy_o, perf_stall_o;

  int checks   = 0;
  int failures = 0;

  tpu_ctrl #(.DIM(DIM), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
    .wren_A_i(wren_A_i), .wren_B_i(wren_B_i), .wren_C_i(wren_C_i),
    .row_i(row_i), .col_i(col_i), .data_i(data_i),
    .tpu_A_we_o(tpu_A_we_o), .tpu_B_we_o(tpu_B_we_o), .tpu_C_we_o(tpu_C_we_o),
    .tpu_row_o(tpu_row_o), .tpu_col_o(tpu_col_o), .tpu_data_o(tpu_data_o),
    .tpu_en_o(tpu_en_o), .tpu_cycle_o(tpu_cycle_o), .busy_o(busy_o),
    .done_o(done_o), .stall_o(stall_o), .err_o(err_o),
    .perf_busy_o(perf_busy_o), .perf_stall_o(perf_stall_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock and stop at the next falling edge.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic clear_cmd();
    start_i = 1'b0; wren_A_i = 1'b0; wren_B_i = 1'b0; wren_C_i = 1'b0;
    row_i = '0; col_i = '0; data_i = '0;
  endtask

  task automatic test_reset();
    clear_cmd();
    rst_n_i = 1'b0;
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
    checks++; if (tpu_en_o !== 1'b0) begin failures++; $display("FAIL reset_en got=%0b exp=0", tpu_en_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall_o); end
    checks++; if (tpu_cycle_o !== 5'd0) begin failures++; $display("FAIL reset_cycle got=%0d exp=0", tpu_cycle_o); end
    checks++; if ({tpu_A_we_o, tpu_B_we_o, tpu_C_we_o} !== 3'b000) begin failures++; $display("FAIL reset_we got=%b exp=000", {tpu_A_we_o, tpu_B_we_o, tpu_C_we_o}); end
    checks++; if (perf_busy_o !== 32'd0 || perf_stall_o !== 32'd0) begin failures++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_busy_o, perf_stall_o); end
    rst_n_i = 1'b1;
    step();
  endtask

  task automatic test_load();
    wren_A_i = 1'b1; row_i = 5'd3; col_i = 5'd5; data_i = 32'hDEADBEEF;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL load_stall_req got=%0b exp=0", stall_o); end
    step();
    clear_cmd();
    checks++; if (tpu_A_we_o !== 1'b1) begin failures++; $display("FAIL load_we got=%0b exp=1", tpu_A_we_o); end
    checks++; if (tpu_row_o !== 5'd3 || tpu_col_o !== 5'd5) begin failures++; $display("FAIL load_rowcol got=%0d,%0d exp=3,5", tpu_row_o, tpu_col_o); end
    checks++; if (tpu_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL load_data got=%h exp=deadbeef", tpu_data_o); end
    checks++; if (tpu_B_we_o !== 1'b0 || tpu_C_we_o !== 1'b0) begin failures++; $display("FAIL load_other_we got=%b%b exp=00", tpu_B_we_o, tpu_C_we_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL load_stall got=%0b exp=0", stall_o); end
    step();
    checks++; if (tpu_A_we_o !== 1'b0) begin failures++; $display("FAIL load_we_drop got=%0b exp=0", tpu_A_we_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL load_err got=%0b exp=0", err_o); end
  endtask

  task automatic test_compute();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < CYC; i++) begin
      checks++; if (tpu_en_o !== 1'b1 || tpu_cycle_o !== 5'(i)) begin failures++; $display("FAIL comp_en_cycle i=%0d got en=%0b cyc=%0d exp en=1 cyc=%0d", i, tpu_en_o, tpu_cycle_o, i); end
      checks++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin failures++; $display("FAIL comp_busy i=%0d got busy=%0b done=%0b exp 1,0", i, busy_o, done_o); end
      step();
    end
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b1 || tpu_en_o !== 1'b0) begin failures++; $display("FAIL comp_done got done=%0b busy=%0b en=%0b exp 1,1,0", done_o, busy_o, tpu_en_o); end
    checks++; if (tpu_cycle_o !== 5'd0) begin failures++; $display("FAIL comp_cycle_hold got=%0d exp=0", tpu_cycle_o); end
    step();
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin failures++; $display("FAIL comp_idle got busy=%0b done=%0b exp 0,0", busy_o, done_o); end
  endtask

  task automatic test_range();
    wren_C_i = 1'b1; row_i = 5'd8; col_i = 5'd0; data_i = 32'h0000_00AA;
    step();
    checks++; if (tpu_C_we_o !== 1'b0) begin failures++; $display("FAIL range_we got=%0b exp=0", tpu_C_we_o); end
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL range_err got=%0b exp=1", err_o); end
    row_i = 5'd7; col_i = 5'd7; data_i = 32'h0000_0055;
    step();
    clear_cmd();
    checks++; if (tpu_C_we_o !== 1'b1 || tpu_row_o !== 5'd7 || tpu_col_o !== 5'd7) begin failures++; $display("FAIL range_legal got we=%0b row=%0d col=%0d exp 1,7,7", tpu_C_we_o, tpu_row_o, tpu_col_o); end
    checks++; if (tpu_data_o !== 32'h0000_0055) begin failures++; $display("FAIL range_legal_data got=%h exp=00000055", tpu_data_o); end
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL range_err_sticky got=%0b exp=1", err_o); end
    step();
  endtask

  task automatic test_reset_mid();
    int en_cnt;
    int done_cnt;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 10; i++) step();
    checks++; if (tpu_cycle_o !== 5'd10) begin failures++; $display("FAIL rmid_pre_cycle got=%0d exp=10", tpu_cycle_o); end
    wren_A_i = 1'b1;
    rst_n_i = 1'b0;
    #1;
    checks++; if (tpu_en_o !== 1'b0 || busy_o !== 1'b0 || tpu_cycle_o !== 5'd0) begin failures++; $display("FAIL rmid_outs got en=%0b busy=%0b cyc=%0d exp 0,0,0", tpu_en_o, busy_o, tpu_cycle_o); end
    checks++; if (err_o !== 1'b0 || stall_o !== 1'b0) begin failures++; $display("FAIL rmid_err_stall got err=%0b stall=%0b exp 0,0", err_o, stall_o); end
    clear_cmd();
    #2;
    rst_n_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    en_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < CYC + 6; i++) begin
      if (tpu_en_o === 1'b1) en_cnt++;
      if (done_o === 1'b1) done_cnt++;
      step();
    end
    checks++; if (en_cnt != CYC) begin failures++; $display("FAIL rmid_run_len got=%0d exp=%0d", en_cnt, CYC); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL rmid_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    int b_cnt;
    logic [31:0] exp_pb, exp_ps;
`ifdef TPU_CTRL_PERF_EN
    exp_pb = 32'd23; exp_ps = 32'd22;
`else
    exp_pb = 32'd0;  exp_ps = 32'd0;
`endif
    rst_n_i = 1'b0;
    #2;
    rst_n_i = 1'b1;
    @(negedge clk_i);
    b_cnt = 0;
    // The next edge is edge t, which accepts the start.
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL stall_no_cmd got=%0b exp=0", stall_o); end
    step();
    // Cycle t+2: the B write appears and is held.
    wren_B_i = 1'b1; row_i = 5'd1; col_i = 5'd2; data_i = 32'h0000_1234;
    for (int i = 2; i <= CYC + 1; i++) begin
      #1;
      checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL stall_hi cyc=t+%0d got=%0b exp=1", i, stall_o); end
      if (tpu_B_we_o === 1'b1) b_cnt++;
      step();
    end
    // Cycle t+24: the controller is IDLE and accepts the write.
    checks++; if (stall_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL stall_release got stall=%0b busy=%0b exp 0,0", stall_o, busy_o); end
    if (tpu_B_we_o === 1'b1) b_cnt++;
    step();
    clear_cmd();
    checks++; if (tpu_B_we_o !== 1'b1 || tpu_row_o !== 5'd1 || tpu_col_o !== 5'd2 || tpu_data_o !== 32'h0000_1234) begin failures++; $display("FAIL stall_fwd got we=%0b row=%0d col=%0d data=%h exp 1,1,2,00001234", tpu_B_we_o, tpu_row_o, tpu_col_o, tpu_data_o); end
    if (tpu_B_we_o === 1'b1) b_cnt++;
    step();
    if (tpu_B_we_o === 1'b1) b_cnt++;
    checks++; if (b_cnt != 1) begin failures++; $display("FAIL stall_wr_count got=%0d exp=1", b_cnt); end
    checks++; if (perf_busy_o !== exp_pb) begin failures++; $display("FAIL perf_busy got=%0d exp=%0d", perf_busy_o, exp_pb); end
    checks++; if (perf_stall_o !== exp_ps) begin failures++; $display("FAIL perf_stall got=%0d exp=%0d", perf_stall_o, exp_ps); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_compute();
    test_range();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
